// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing one fixed-latency single-port memory between
// instruction fetch and the MEM stage; data port wins ties unless fetch is starved.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] S_LIMIT  = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic              own_d_q, own_d_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [3:0]        starve_q, starve_d;
  logic              grant_d;

  always_comb begin
    state_d    = state_q;
    own_d_d    = own_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    wcnt_d     = wcnt_q;
    starve_d   = starve_q;
    grant_d    = d_req & (~if_req | (starve_q != S_LIMIT));
    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          state_d = ISSUE;
          own_d_d = grant_d;
          addr_d  = grant_d ? d_addr : if_addr;
          we_d    = grant_d & d_we;
          if (grant_d) wdata_d = d_wdata;
          // fetch cannot lose once the counter is at the limit, so no overflow
          if (!grant_d) starve_d = '0;
          else if (if_req) starve_d = starve_q + 4'd1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wcnt_d  = '0;
      end
      WAIT: begin
        if (wcnt_q == LAT_LAST) begin
          state_d = RESP;
          if (!we_q) begin
            if (own_d_q) d_rdata_d = mem_rdata;
            else if_rdata_d = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      own_d_q    <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      wcnt_q     <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      own_d_q    <= own_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      wcnt_q     <= wcnt_d;
      starve_q   <= starve_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = (state_q == RESP) & ~own_d_q;
  assign d_ready   = (state_q == RESP) & own_d_q;
  assign busy      = (state_q != IDLE);
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle table, directed
// multi-cycle sequences, then random traffic against a timing-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;
  localparam int SL  = 3;

  logic clk = 1'b0;
  logic reset;
  logic if_req, if_ready;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic d_req, d_we, d_ready;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic stall_if, stall_mem, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL)
  ) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
  );

  function automatic logic [31:0] pat(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // memory: read data is valid only in the cycle LAT after mem_en
  logic [31:0] memarr [0:255];
  bit minit = 1'b0;
  int mcnt = 0;
  logic [7:0] mpend = '0;

  always @(posedge clk) begin
    if (!minit) begin
      for (int i = 0; i < 256; i++) memarr[i] <= pat(i);
      memarr[4] <= 32'hDEAD_BEEF;
      minit <= 1'b1;
    end else begin
      if (mem_en && mem_we) memarr[mem_addr[9:2]] <= mem_wdata;
      if (mem_en && !mem_we) begin
        mpend <= mem_addr[9:2];
        mcnt  <= LAT;
      end else if (mcnt > 0) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  assign mem_rdata = (mcnt == 1) ? memarr[mpend] : 32'hBAD0_BAD0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic rst, ir, dr;
    logic en, ird, drd, sif, sm, bsy;
  } vec_t;

  vec_t tbl [15];

  int en_c, rd_c, cnt, n;
  int seq [8];
  bit found;

  logic [31:0] ref_mem [0:255];
  int free_c, g_c, iss_c, rdy_c, starve;
  bit m_if, m_we, gi, e_ir, e_dr, ia, da;
  logic [31:0] m_addr, m_wd, m_rd, exp_ifr, exp_dr;

  initial begin
    //            rst ir dr  en ird drd sif sm bsy
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h40;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h10; d_wdata = '0;
    repeat (2) @(posedge clk);

    // reset, D load at 0x10, then IF fetch at 0x40, then idle
    for (int i = 0; i < 15; i++) begin
      next();
      reset = tbl[i].rst; if_req = tbl[i].ir; d_req = tbl[i].dr;
      @(negedge clk);
      chkb("tbl_mem_en", mem_en, tbl[i].en);
      chkb("tbl_if_ready", if_ready, tbl[i].ird);
      chkb("tbl_d_ready", d_ready, tbl[i].drd);
      chkb("tbl_stall_if", stall_if, tbl[i].sif);
      chkb("tbl_stall_mem", stall_mem, tbl[i].sm);
      chkb("tbl_busy", busy, tbl[i].bsy);
      if (tbl[i].rst) begin
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
      end
      if (tbl[i].en) chk("tbl_mem_addr", mem_addr, tbl[i].dr ? 32'h10 : 32'h40);
      if (tbl[i].drd) chk("tbl_d_rdata", d_rdata, 32'hDEAD_BEEF);
      if (tbl[i].ird) chk("tbl_if_rdata", if_rdata, pat(16));
    end

    // store: issue cycle 1, ready cycle LAT+2, load data untouched
    next();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    en_c = -1; rd_c = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_en && en_c < 0) begin
        en_c = k;
        chkb("st_mem_we", mem_we, 1'b1);
        chk("st_mem_addr", mem_addr, 32'h20);
        chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
      end
      if (d_ready) begin
        rd_c = k;
        break;
      end
      next();
    end
    chk("st_en_cycle", en_c, 1);
    chk("st_rdy_cycle", rd_c, LAT + 2);
    chk("st_d_rdata", d_rdata, 32'hDEAD_BEEF);
    next();
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h10;
    chk("st_mem_word", memarr[8], 32'h1234_5678);

    // contention: SL data wins, then one forced fetch, repeating
    next();
    if_req = 1'b1; d_req = 1'b1; if_addr = 32'h40; d_addr = 32'h10;
    n = 0;
    for (int k = 0; k < 8; k++) seq[k] = 9;
    for (int k = 0; k < 8 * (LAT + 3) + 8; k++) begin
      @(negedge clk);
      if (d_ready) begin
        if (n < 8) seq[n] = 0;
        n++;
        chk("cont_d_rdata", d_rdata, 32'hDEAD_BEEF);
      end
      if (if_ready) begin
        if (n < 8) seq[n] = 1;
        n++;
        chk("cont_if_rdata", if_rdata, pat(16));
      end
      if (n >= 8) break;
      next();
    end
    for (int k = 0; k < 8; k++)
      chk("cont_grant", seq[k], (k % (SL + 1) == SL) ? 1 : 0);
    next();
    if_req = 1'b0; d_req = 1'b0;

    // fetch request dropped during WAIT still completes once
    next();
    if_req = 1'b1; if_addr = 32'h44;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_en) begin
        found = 1'b1;
        break;
      end
      next();
    end
    chkb("drop_issue_seen", found, 1'b1);
    next();
    if_req = 1'b0;
    cnt = 0;
    for (int j = 0; j < LAT + 6; j++) begin
      @(negedge clk);
      if (if_ready) begin
        cnt++;
        chk("drop_if_rdata", if_rdata, pat(17));
      end
      next();
    end
    @(negedge clk);
    chk("drop_ready_count", cnt, 1);
    chkb("drop_idle_busy", busy, 1'b0);

    // reset during WAIT aborts the load
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (mem_en) begin
        found = 1'b1;
        break;
      end
      next();
    end
    chkb("rw_issue_seen", found, 1'b1);
    next();
    reset = 1'b1; d_req = 1'b0;
    next();
    reset = 1'b0;
    cnt = 0;
    for (int j = 0; j < LAT + 4; j++) begin
      @(negedge clk);
      if (d_ready) cnt++;
      chkb("rw_mem_en", mem_en, 1'b0);
      chkb("rw_busy", busy, 1'b0);
      next();
    end
    chk("rw_ready_count", cnt, 0);
    chk("rw_d_rdata", d_rdata, 32'h0);
    chk("rw_if_rdata", if_rdata, 32'h0);

    // random traffic against a cycle-timing transaction model
    for (int i = 0; i < 256; i++) ref_mem[i] = memarr[i];
    free_c = 0; g_c = -100; iss_c = -100; rdy_c = -100; starve = 0;
    m_if = 1'b0; m_we = 1'b0; m_addr = '0; m_wd = '0; m_rd = '0;
    exp_ifr = '0; exp_dr = '0; e_ir = 1'b0; e_dr = 1'b0;
    ia = 1'b0; da = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next();
      if (ia && (e_ir || $urandom_range(0, 39) == 0)) ia = 1'b0;
      else if (!ia && $urandom_range(0, 2) == 0) begin
        ia = 1'b1;
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (da && (e_dr || $urandom_range(0, 39) == 0)) da = 1'b0;
      else if (!da && $urandom_range(0, 2) == 0) begin
        da = 1'b1;
        d_addr = 32'($urandom_range(0, 255)) << 2;
        d_we = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
      end
      if_req = ia; d_req = da;
      @(negedge clk);
      e_ir = (c == rdy_c) && m_if;
      e_dr = (c == rdy_c) && !m_if;
      if (e_ir) exp_ifr = m_rd;
      if (e_dr && !m_we) exp_dr = m_rd;
      if (c >= free_c && (if_req || d_req)) begin
        gi = if_req && (!d_req || starve == SL);
        if (gi) starve = 0;
        else if (if_req) starve = (starve + 1 > SL) ? SL : starve + 1;
        m_if = gi;
        m_addr = gi ? if_addr : d_addr;
        m_we = !gi && d_we;
        m_wd = d_wdata;
        if (m_we) ref_mem[m_addr[9:2]] = m_wd;
        else m_rd = ref_mem[m_addr[9:2]];
        g_c = c; iss_c = c + 1; rdy_c = c + LAT + 2; free_c = c + LAT + 3;
      end
      chkb("rnd_mem_en", mem_en, c == iss_c);
      if (c == iss_c) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chkb("rnd_mem_we", mem_we, m_we);
        if (m_we) chk("rnd_mem_wdata", mem_wdata, m_wd);
      end
      chkb("rnd_busy", busy, c > g_c && c <= rdy_c);
      chkb("rnd_if_ready", if_ready, e_ir);
      chkb("rnd_d_ready", d_ready, e_dr);
      chk("rnd_if_rdata", if_rdata, exp_ifr);
      chk("rnd_d_rdata", d_rdata, exp_dr);
      chkb("rnd_stall_if", stall_if, if_req && !e_ir);
      chkb("rnd_stall_mem", stall_mem, d_req && !e_dr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency memory between the instruction-fetch stage and the MEM stage of the MIPS pipelined processor. It accepts one request per port, grants the memory to one requester at a time (data port priority, with a starvation guard for fetch), drives the memory control signals, returns read data with a one-cycle ready pulse, and produces stall signals that freeze the pipeline while a port is waiting.

## Interface
- ADDR_W, 32, address width (byte address, passed through unchanged)
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal 1..15
- STARVE_LIMIT, 3, consecutive fetch losses before fetch is forced to win; legal 1..15

- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready
- if_ready  out  1  one-cycle completion pulse, fetch port
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_ready
- d_ready  out  1  one-cycle completion pulse, data port
- mem_en  out  1  one-cycle memory access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- stall_if  out  1  = if_req & ~if_ready (combinational)
- stall_mem  out  1  = d_req & ~d_ready (combinational)
- busy  out  1  1 in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Registers: owner (IF/D), latched addr/we/wdata, wait counter, starve counter.
- IDLE: if any req, arbitrate, latch owner's addr/we/wdata, go ISSUE. No req: stay.
- Arbitration: only d_req -> D; only if_req -> IF; both -> D unless starve_cnt == STARVE_LIMIT, then IF.
- starve_cnt: +1 when both request and D wins; cleared when IF is granted; not changed otherwise; saturates at STARVE_LIMIT.
- ISSUE (1 cycle): mem_en=1, mem_we/mem_addr/mem_wdata from latched values. -> WAIT.
- WAIT (exactly MEM_LATENCY cycles): mem_en=0. Last WAIT cycle: if read, capture mem_rdata into owner's rdata register. -> RESP.
- RESP (1 cycle): owner's ready=1. -> IDLE. Req inputs ignored outside IDLE.
- Writes never update d_rdata or if_rdata; if_rdata/d_rdata hold last captured value until next read by that port.
- Fetch port is always a read (mem_we=0 on IF grant).
- Req dropped before ready: transaction still completes, ready still pulses; requester discards it.
- mem_addr/mem_we/mem_wdata hold latched values outside ISSUE; only mem_en qualifies them.

## Timing
- Reset (synchronous): state IDLE; mem_en, mem_we, if_ready, d_ready, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; counters 0; owner = IF.
- Reset mid-transaction: transaction aborted, no ready pulse, mem_en 0 from the next cycle.
- Req sampled high in IDLE cycle 0 -> ISSUE cycle 1 -> WAIT cycles 2..MEM_LATENCY+1 (mem_rdata valid in cycle MEM_LATENCY+1) -> ready in cycle MEM_LATENCY+2 -> IDLE cycle MEM_LATENCY+3.
- Per-access occupancy MEM_LATENCY+3 cycles; back-to-back requests from a held req start in the IDLE cycle after RESP.
- stall_* drop in the same cycle ready rises; pipeline advances on that edge.
- Loser port's req stays pending; it is re-arbitrated at the next IDLE.

## Test plan
- Reset: reset high 1 cycle with both reqs high -> all outputs 0, busy 0; first mem_en in cycle 2 after reset deasserts.
- Single load, MEM_LATENCY=1: d_req, d_addr=0x10, memory returns 0xDEADBEEF -> mem_en in cycle 1, d_ready + d_rdata=0xDEADBEEF in cycle 3, stall_mem 1 in cycles 0-2.
- Store, MEM_LATENCY=3: d_we=1, d_addr=0x20, d_wdata=0x12345678 -> mem_en & mem_we with those values in cycle 1, d_ready in cycle 5, d_rdata unchanged.
- Contention, STARVE_LIMIT=3: if_req and d_req both held continuously -> grant order D, D, D, IF, D, D, D, IF; if_rdata matches fetch address data.
- Dropped req: if_req falls in WAIT -> if_ready still pulses once in RESP; next IDLE with no req stays idle, busy 0.
- Reset in WAIT: assert reset during WAIT of a load -> no d_ready, state IDLE, d_rdata 0 after reset.
